// File: rtl/i2s_stream_xcvr_pkg.sv
// i2s_stream_xcvr_pkg: shared I2S slot definitions for the stream transceiver
package i2s_stream_xcvr_pkg;
  typedef enum logic {SLOT_L = 1'b0, SLOT_R = 1'b1} slot_e;
  localparam int MSB_BIT = 1;
  function automatic logic data_bit(input int b, input int w);
    return b >= MSB_BIT && b < MSB_BIT + w;
  endfunction
endpackage

// File: rtl/i2s_sync_fifo.sv
// i2s_sync_fifo: synchronous FIFO with occupancy count and registered read data
module i2s_sync_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 1024,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_100mhz,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [W-1:0]     din,
  input  logic             rd_en,
  output logic [W-1:0]     dout,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr_ok, rd_ok;
  assign full  = count == CNT_W'(DEPTH);
  assign empty = count == '0;
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;
  always_ff @(posedge clk_100mhz)
    if (wr_ok) mem[wp] <= din;
  always_ff @(posedge clk_100mhz)
    if (!aresetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) begin
        rp   <= rp + AW'(1);
        dout <= mem[rp];
      end
      valid <= rd_ok;
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
    end
endmodule

// File: rtl/i2s_stream_xcvr.sv
// i2s_stream_xcvr: I2S master transceiver with RX/TX sample FIFOs, L/R swap, TX mono and sticky errors
module i2s_stream_xcvr
  import i2s_stream_xcvr_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int SLOT_W     = 32,
  parameter int BCLK_DIV   = 32,
  parameter int FIFO_DEPTH = 1024,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk_100mhz,
  input  logic                aresetn,
  input  logic                rx_en,
  input  logic                tx_en,
  input  logic                swap_lr,
  input  logic                tx_mono,
  input  logic                err_clr,
  input  logic                rx_rd_en,
  output logic [2*DATA_W-1:0] rx_data,
  output logic                rx_valid,
  output logic [CNT_W-1:0]    rx_count,
  output logic                rx_empty,
  output logic                rx_full,
  output logic                rx_ovf,
  input  logic                tx_wr_en,
  input  logic [2*DATA_W-1:0] tx_data,
  output logic [CNT_W-1:0]    tx_count,
  output logic                tx_empty,
  output logic                tx_full,
  output logic                tx_udr,
  output logic                bclk,
  output logic                lrclk,
  input  logic                sdata_i,
  output logic                sdata_o
);
  localparam int HALF = BCLK_DIV / 2;
  localparam int DW = $clog2(HALF);
  localparam int BW = $clog2(SLOT_W);
  logic [DW-1:0] div;
  logic [BW-1:0] bit_cnt, nb;
  logic tick, rise, fall, bit_last, frame_start, nlr, tx_bit;
  logic rx_act, rx_swap, rx_push, tx_pop, tx_vld;
  logic [2*DATA_W-1:0] rx_sh, rx_word, tx_q;
  logic [DATA_W-1:0] tx_l, tx_r, sw_l, sw_r;
  assign tick        = div == DW'(HALF - 1);
  assign rise        = tick & ~bclk;
  assign fall        = tick & bclk;
  assign bit_last    = bit_cnt == BW'(SLOT_W - 1);
  assign frame_start = rise & (lrclk == SLOT_L) & (bit_cnt == '0);
  always_ff @(posedge clk_100mhz)
    if (!aresetn) begin
      div     <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
      lrclk   <= 1'b0;
    end else begin
      div <= tick ? '0 : div + DW'(1);
      if (tick) bclk <= ~bclk;
      if (fall) bit_cnt <= bit_last ? '0 : bit_cnt + BW'(1);
      if (fall && bit_last) lrclk <= ~lrclk;
    end
  // RX enable and swap are frozen at frame start so only whole frames are pushed
  assign rx_word = rx_swap ? {rx_sh[DATA_W-1:0], rx_sh[2*DATA_W-1:DATA_W]} : rx_sh;
  always_ff @(posedge clk_100mhz)
    if (!aresetn) begin
      rx_sh   <= '0;
      rx_act  <= 1'b0;
      rx_swap <= 1'b0;
      rx_push <= 1'b0;
    end else begin
      if (rise && data_bit(int'(bit_cnt), DATA_W)) rx_sh <= {rx_sh[2*DATA_W-2:0], sdata_i};
      if (frame_start) begin
        rx_act  <= rx_en;
        rx_swap <= swap_lr;
      end
      rx_push <= rise & (lrclk == SLOT_R) & (bit_cnt == BW'(DATA_W)) & rx_act;
    end
  // nb/nlr describe the bit slot that begins at this bclk fall
  assign nb     = bit_last ? '0 : bit_cnt + BW'(1);
  assign nlr    = lrclk ^ bit_last;
  assign tx_bit = data_bit(int'(nb), DATA_W);
  assign tx_pop = frame_start & tx_en & ~tx_empty;
  assign sw_l   = swap_lr ? tx_q[DATA_W-1:0] : tx_q[2*DATA_W-1:DATA_W];
  assign sw_r   = tx_mono ? sw_l : swap_lr ? tx_q[2*DATA_W-1:DATA_W] : tx_q[DATA_W-1:0];
  always_ff @(posedge clk_100mhz)
    if (!aresetn) begin
      tx_l    <= '0;
      tx_r    <= '0;
      sdata_o <= 1'b0;
    end else begin
      if (frame_start) begin
        tx_l <= '0;
        tx_r <= '0;
      end
      if (tx_vld) begin
        tx_l <= sw_l;
        tx_r <= sw_r;
      end
      if (fall && tx_bit && nlr) tx_r <= {tx_r[DATA_W-2:0], 1'b0};
      if (fall && tx_bit && !nlr) tx_l <= {tx_l[DATA_W-2:0], 1'b0};
      if (fall) sdata_o <= tx_bit & (nlr ? tx_r[DATA_W-1] : tx_l[DATA_W-1]);
    end
  always_ff @(posedge clk_100mhz)
    if (!aresetn) begin
      rx_ovf <= 1'b0;
      tx_udr <= 1'b0;
    end else begin
      rx_ovf <= (rx_push & rx_full) | (rx_ovf & ~err_clr);
      tx_udr <= (frame_start & tx_en & tx_empty) | (tx_udr & ~err_clr);
    end
  i2s_sync_fifo #(.W(2*DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .clk_100mhz(clk_100mhz), .aresetn(aresetn), .wr_en(rx_push), .din(rx_word),
    .rd_en(rx_rd_en), .dout(rx_data), .valid(rx_valid), .count(rx_count),
    .empty(rx_empty), .full(rx_full)
  );
  i2s_sync_fifo #(.W(2*DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .clk_100mhz(clk_100mhz), .aresetn(aresetn), .wr_en(tx_wr_en), .din(tx_data),
    .rd_en(tx_pop), .dout(tx_q), .valid(tx_vld), .count(tx_count),
    .empty(tx_empty), .full(tx_full)
  );
endmodule
